// File: rtl/snake_pkg.sv
// Shared types and helpers for the Snake game controller: direction encoding,
// game state encoding, reversal helper and the speed-up period function.
package snake_pkg;

    // Direction encoding; flipping bit 1 gives the opposite direction.
    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_LEFT  = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } state_t;

    function automatic dir_t opposite(input dir_t d);
        return d ^ 2'b10;
    endfunction

    // max(min_p, base - len/4), never below 1 so the frame counter always wraps.
    function automatic logic [4:0] speedup_period(input int unsigned base,
                                                  input int unsigned min_p,
                                                  input logic [6:0] len);
        int p;
        p = int'(base) - int'({25'd0, len[6:2]});
        if (p < int'(min_p)) p = int'(min_p);
        if (p < 1) p = 1;
        return p[4:0];
    endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// Two-entry direction queue. Requests that repeat or reverse the reference
// direction (queue tail, or the current direction when the queue is empty)
// are discarded. A pop in the same cycle as a push is applied first, and the
// push is filtered against the post-pop reference.
module snake_dir_fifo
    import snake_pkg::*;
(
    input  logic       VGA_clk,
    input  logic       rst,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [1:0] push_dir_i,
    input  logic       pop_i,
    input  logic [1:0] cur_dir_i,
    output logic [1:0] head_o,
    output logic       empty_o
);

    logic [1:0] slot0_q, slot0_d;
    logic [1:0] slot1_q, slot1_d;
    logic [1:0] count_q, count_d;
    logic [1:0] ref_dir;
    logic       popped;
    logic       accept;

    // Next-state: pop first, then a filtered push, flush overrides both.
    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        popped  = pop_i && (count_q != 2'd0);

        if (popped) begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
        end

        // After a pop that empties the queue, the popped entry becomes the
        // current direction, so it is the reference for this push.
        if (count_d == 2'd2) begin
            ref_dir = slot1_d;
        end else if (count_d == 2'd1) begin
            ref_dir = slot0_d;
        end else if (popped) begin
            ref_dir = slot0_q;
        end else begin
            ref_dir = cur_dir_i;
        end

        accept = push_i && (count_d != 2'd2) && (push_dir_i != ref_dir) &&
                 (push_dir_i != opposite(ref_dir));

        if (accept) begin
            if (count_d == 2'd0) begin
                slot0_d = push_dir_i;
            end else begin
                slot1_d = push_dir_i;
            end
            count_d = count_d + 2'd1;
        end

        if (flush_i) begin
            count_d = 2'd0;
        end
    end

    // Queue storage.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            slot0_q <= DIR_RIGHT;
            slot1_q <= DIR_RIGHT;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/snake_game_sequencer.sv
// Frame-locked Snake game controller: decides when the snake steps, in which
// direction, when it grows, when the apple respawns and when the game ends.
// Optional build macro: SNAKE_SPEEDUP_EN shortens the step period as the
// snake grows; without it the period is FRAMES_PER_STEP.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int unsigned FRAMES_PER_STEP     = 6,
    parameter int unsigned MIN_FRAMES_PER_STEP = 2,
    parameter int unsigned MAX_LEN             = 127
) (
    input  logic       VGA_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       frame_start,
    input  logic       dir_req,
    input  logic [1:0] dir_code,
    input  logic       hit_apple,
    input  logic       hit_lethal,
    output logic       step,
    output logic [1:0] step_dir,
    output logic       grow,
    output logic       apple_respawn,
    output logic       clear,
    output logic [6:0] length,
    output logic       game_over,
    output logic [1:0] state
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_PLAY = PLAY;
    localparam logic [1:0] ST_DEAD = DEAD;

    localparam logic [6:0] MaxLen = 7'(MAX_LEN);

`ifdef SNAKE_SPEEDUP_EN
    localparam logic [4:0] InitPeriod =
        speedup_period(FRAMES_PER_STEP, MIN_FRAMES_PER_STEP, 7'd1);
`else
    localparam logic [4:0] InitPeriod =
        (FRAMES_PER_STEP < 1) ? 5'd1 : 5'(FRAMES_PER_STEP);
`endif

    logic [1:0] state_q, state_d;
    logic       step_q, step_d;
    logic [1:0] step_dir_q, step_dir_d;
    logic       grow_q, grow_d;
    logic       respawn_q, respawn_d;
    logic       clear_q, clear_d;
    logic [6:0] length_q, length_d;
    logic       game_over_q, game_over_d;
    logic [1:0] cur_dir_q, cur_dir_d;
    logic [3:0] cnt_q, cnt_d;
    logic       apple_f_q, apple_f_d;
    logic       lethal_f_q, lethal_f_d;
    logic       grow_pend_q, grow_pend_d;

    logic [4:0] period;
    logic [4:0] period_m1;
    logic       apple_any;
    logic       lethal_any;
    logic       grow_now;
    logic [6:0] length_next;

    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_flush;
    logic [1:0] fifo_head;
    logic       fifo_empty;

`ifdef SNAKE_SPEEDUP_EN
    logic [4:0] period_q, period_d;
    assign period = period_q;
`else
    logic unused_min;
    assign unused_min = ^MIN_FRAMES_PER_STEP;
    assign period = InitPeriod;
`endif

    assign period_m1  = period - 5'd1;
    assign apple_any  = apple_f_q | hit_apple;
    assign lethal_any = lethal_f_q | hit_lethal;
    assign fifo_push  = dir_req && start && (state_q == ST_PLAY);

    // Game FSM, frame counter, sticky collision flags and length.
    always_comb begin
        state_d     = state_q;
        step_d      = 1'b0;
        grow_d      = 1'b0;
        respawn_d   = 1'b0;
        clear_d     = 1'b0;
        step_dir_d  = step_dir_q;
        length_d    = length_q;
        cur_dir_d   = cur_dir_q;
        cnt_d       = cnt_q;
        apple_f_d   = apple_f_q;
        lethal_f_d  = lethal_f_q;
        grow_pend_d = grow_pend_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        grow_now    = 1'b0;
        length_next = length_q;
`ifdef SNAKE_SPEEDUP_EN
        period_d    = period_q;
`endif

        if (!start) begin
            state_d     = ST_IDLE;
            apple_f_d   = 1'b0;
            lethal_f_d  = 1'b0;
            grow_pend_d = 1'b0;
            fifo_flush  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_d     = ST_PLAY;
                        clear_d     = 1'b1;
                        respawn_d   = 1'b1;
                        length_d    = 7'd1;
                        cur_dir_d   = DIR_RIGHT;
                        cnt_d       = 4'd0;
                        fifo_flush  = 1'b1;
                        apple_f_d   = 1'b0;
                        lethal_f_d  = 1'b0;
                        grow_pend_d = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
                        period_d    = InitPeriod;
`endif
                    end
                end

                ST_PLAY: begin
                    apple_f_d  = apple_any;
                    lethal_f_d = lethal_any;
                    if (frame_start) begin
                        apple_f_d  = 1'b0;
                        lethal_f_d = 1'b0;
                        if (lethal_any) begin
                            state_d = ST_DEAD;
                        end else begin
                            grow_now = grow_pend_q;
                            if (apple_any) begin
                                respawn_d = 1'b1;
                                grow_now  = 1'b1;
                            end
                            grow_pend_d = grow_now;

                            if ({1'b0, cnt_q} == period_m1) begin
                                cnt_d    = 4'd0;
                                step_d   = 1'b1;
                                fifo_pop = 1'b1;
                                if (!fifo_empty) begin
                                    cur_dir_d  = fifo_head;
                                    step_dir_d = fifo_head;
                                end else begin
                                    step_dir_d = cur_dir_q;
                                end
                                grow_d = grow_now;
                                if (grow_now) begin
                                    grow_pend_d = 1'b0;
                                    if (length_q < MaxLen) begin
                                        length_next = length_q + 7'd1;
                                    end
                                end
                                length_d = length_next;
`ifdef SNAKE_SPEEDUP_EN
                                period_d = speedup_period(FRAMES_PER_STEP,
                                                          MIN_FRAMES_PER_STEP,
                                                          length_next);
`endif
                            end else if ({1'b0, cnt_q} >= period) begin
                                // Period shrank below the running count.
                                cnt_d = 4'd0;
                            end else begin
                                cnt_d = cnt_q + 4'd1;
                            end
                        end
                    end
                end

                ST_DEAD: begin
                    state_d = ST_DEAD;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        game_over_d = (state_d == ST_DEAD);
    end

    // Registered state and outputs.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= 1'b0;
            step_dir_q  <= DIR_RIGHT;
            grow_q      <= 1'b0;
            respawn_q   <= 1'b0;
            clear_q     <= 1'b0;
            length_q    <= 7'd1;
            game_over_q <= 1'b0;
            cur_dir_q   <= DIR_RIGHT;
            cnt_q       <= 4'd0;
            apple_f_q   <= 1'b0;
            lethal_f_q  <= 1'b0;
            grow_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            step_dir_q  <= step_dir_d;
            grow_q      <= grow_d;
            respawn_q   <= respawn_d;
            clear_q     <= clear_d;
            length_q    <= length_d;
            game_over_q <= game_over_d;
            cur_dir_q   <= cur_dir_d;
            cnt_q       <= cnt_d;
            apple_f_q   <= apple_f_d;
            lethal_f_q  <= lethal_f_d;
            grow_pend_q <= grow_pend_d;
        end
    end

`ifdef SNAKE_SPEEDUP_EN
    // Step period tracks the length, updated at each step.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            period_q <= InitPeriod;
        end else begin
            period_q <= period_d;
        end
    end
`endif

    snake_dir_fifo u_dir_fifo (
        .VGA_clk    (VGA_clk),
        .rst        (rst),
        .flush_i    (fifo_flush),
        .push_i     (fifo_push),
        .push_dir_i (dir_code),
        .pop_i      (fifo_pop),
        .cur_dir_i  (cur_dir_q),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty)
    );

    assign step          = step_q;
    assign step_dir      = step_dir_q;
    assign grow          = grow_q;
    assign apple_respawn = respawn_q;
    assign clear         = clear_q;
    assign length        = length_q;
    assign game_over     = game_over_q;
    assign state         = state_q;

endmodule
